spi_master_ctrl: RTL and testbench

SPI master transaction controller that sequences a single 8-bit shift engine and shares it between NUM_REQ requesters. Each accepted request drives one full-duplex byte transfer (SPI mode 0, MSB first) on a dedicated chip select. The received byte is returned with the requester index. It sits between on-chip clients and the external SPI pins and replaces ad-hoc per-client serializers.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_master_ctrl_if.sv | 34 +++
 rtl/spi_rr_arbiter.sv | 40 ++++
 rtl/spi_master_ctrl.sv | 146 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg : shared state encoding, data width and helpers for the SPI master
// Rev 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_BIT_W  = $clog2(SPI_DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } spi_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master_ctrl_if : requester handshake, response and SPI pin bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface spi_master_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = spi_pkg::id_width(NUM_REQ)
) ();
  import spi_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [SPI_DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsp_valid;
  logic [SPI_DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]               rsp_id;
  logic                          sclk;
  logic                          mosi;
  logic                          miso;
  logic [NUM_REQ-1:0]            cs_n;

  modport master (
    input  req_valid, req_data, miso,
    output req_ready, rsp_valid, rsp_data, rsp_id, sclk, mosi, cs_n
  );

  modport slave (
    output req_valid, req_data, miso,
    input  req_ready, rsp_valid, rsp_data, rsp_id, sclk, mosi, cs_n
  );

endinterface
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_rr_arbiter : combinational round-robin pick starting at ptr_i
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  int            idx;
  logic [ID_W-1:0] idx_sel;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    any_o   = 1'b0;
    idx     = 0;
    idx_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx     = (int'(ptr_i) + k) % NUM_REQ;
      idx_sel = ID_W'(idx);
      if (req_i[idx_sel]) begin
        gnt_o          = '0;
        gnt_o[idx_sel] = 1'b1;
        id_o           = idx_sel;
        any_o          = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master_ctrl : shares one mode-0 byte shifter between NUM_REQ requesters
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NUM_REQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_ctrl_if.master bus
);

  localparam int              ID_W    = id_width(NUM_REQ);
  localparam int              PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_master_ctrl: CLK_DIV must be >= 1");
  end
  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("spi_master_ctrl: NUM_REQ must be in 1..8");
  end

  spi_state_e                state_q;
  logic [PH_W-1:0]           phase_q;
  logic [SPI_BIT_W-1:0]      bit_q;
  logic [SPI_DATA_W-1:0]     tx_q;
  logic [SPI_DATA_W-1:0]     rx_q;
  logic [ID_W-1:0]           id_q;
  logic [ID_W-1:0]           ptr_q;
  logic [ID_W-1:0]           ptr_d;
  logic                      sclk_q;
  logic                      mosi_q;
  logic [NUM_REQ-1:0]        cs_n_q;
  logic                      rsp_valid_q;
  logic [SPI_DATA_W-1:0]     rsp_data_q;
  logic [ID_W-1:0]           rsp_id_q;

  logic [NUM_REQ-1:0]        gnt;
  logic [ID_W-1:0]           gnt_id;
  logic                      gnt_any;
  logic                      grant_en;
  logic                      accept;
  logic                      phase_last;
  logic [SPI_DATA_W-1:0]     req_byte;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .id_o  (gnt_id),
    .any_o (gnt_any)
  );

  // The response cycle is spent in IDLE but must not grant, which guarantees
  // at least one idle cycle with all chip selects high between transfers.
  assign grant_en   = rst_n && (state_q == IDLE) && !rsp_valid_q;
  assign accept     = grant_en && gnt_any;
  assign ptr_d      = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  assign req_byte   = bus.req_data[gnt_id*SPI_DATA_W +: SPI_DATA_W];
  assign phase_last = (phase_q == PH_LAST);

  assign bus.req_ready = grant_en ? gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.sclk      = sclk_q;
  assign bus.mosi      = mosi_q;
  assign bus.cs_n      = cs_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= '1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q != IDLE) begin
        phase_q <= phase_last ? '0 : phase_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SETUP;
            phase_q <= '0;
            bit_q   <= '0;
            tx_q    <= req_byte;
            mosi_q  <= req_byte[SPI_DATA_W-1];
            id_q    <= gnt_id;
            ptr_q   <= ptr_d;
            cs_n_q  <= ~gnt;
          end
        end
        SETUP, LOW: begin
          if (phase_last) begin
            state_q <= HIGH;
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[SPI_DATA_W-2:0], bus.miso};
          end
        end
        HIGH: begin
          if (phase_last) begin
            sclk_q <= 1'b0;
            if (bit_q == SPI_BIT_W'(SPI_DATA_W - 1)) begin
              state_q <= HOLD;
            end else begin
              state_q <= LOW;
              tx_q    <= {tx_q[SPI_DATA_W-2:0], 1'b0};
              mosi_q  <= tx_q[SPI_DATA_W-2];
              bit_q   <= bit_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (phase_last) begin
            state_q     <= IDLE;
            cs_n_q      <= '1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_q;
            rsp_id_q    <= id_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl : randomized bench against a cycle-window transfer model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int NR = 2;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  int         total      = 0;
  int         bad        = 0;
  int         cyc        = 0;
  logic [7:0] slave_byte = 8'h00;
  int         ptr0_m     = 0;
  int         ptr1_m     = 0;
  logic       sel1       = 1'b0;

  spi_master_ctrl_if #(.NUM_REQ(NR)) b0 ();
  spi_master_ctrl_if #(.NUM_REQ(NR)) b1 ();

  spi_master_ctrl #(.CLK_DIV(2), .NUM_REQ(NR)) dut  (.clk(clk), .rst_n(rst_n), .bus(b0.master));
  spi_master_ctrl #(.CLK_DIV(1), .NUM_REQ(NR)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave: MSB valid at select, next bit after each sclk fall.
  int  sl_cnt0 = 0;
  int  sl_cnt1 = 0;
  wire cs_all0 = &b0.cs_n;
  wire cs_all1 = &b1.cs_n;
  always @(posedge cs_all0 or negedge b0.sclk) begin
    if (cs_all0) sl_cnt0 = 0;
    else if (sl_cnt0 < 7) sl_cnt0 = sl_cnt0 + 1;
  end
  always @(posedge cs_all1 or negedge b1.sclk) begin
    if (cs_all1) sl_cnt1 = 0;
    else if (sl_cnt1 < 7) sl_cnt1 = sl_cnt1 + 1;
  end
  assign b0.miso = slave_byte[3'(7 - sl_cnt0)];
  assign b1.miso = slave_byte[3'(7 - sl_cnt1)];

  wire [NR-1:0] m_ready = sel1 ? b1.req_ready : b0.req_ready;
  wire [NR-1:0] m_cs_n  = sel1 ? b1.cs_n      : b0.cs_n;
  wire          m_sclk  = sel1 ? b1.sclk      : b0.sclk;
  wire          m_mosi  = sel1 ? b1.mosi      : b0.mosi;
  wire          m_rv    = sel1 ? b1.rsp_valid : b0.rsp_valid;
  wire [7:0]    m_rd    = sel1 ? b1.rsp_data  : b0.rsp_data;
  wire [0:0]    m_rid   = sel1 ? b1.rsp_id    : b0.rsp_id;

  function automatic int rr_pick(input logic [NR-1:0] req, input int ptr);
    int w = -1;
    for (int k = NR - 1; k >= 0; k--) if (req[(ptr + k) % NR]) w = (ptr + k) % NR;
    return w;
  endfunction

  task automatic set_req(input logic [NR-1:0] v);
    if (sel1) b1.req_valid = v; else b0.req_valid = v;
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    if (sel1) b1.req_data[8*i +: 8] = d; else b0.req_data[8*i +: 8] = d;
  endtask

  task automatic wait_grant(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (m_ready != '0) begin at = cyc; break; end
      @(negedge clk);
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL grant_timeout got=none required=grant within 200 cycles");
    end
  endtask

  // Expected waveform from the phase index p = (n-1)/D: p=0 setup, odd p high,
  // even p low, p=16 hold; mosi shows bit 7-min(p/2,7).
  task automatic expect_xfer(input string tag, input int id, input logic [7:0] tx,
                             input logic [7:0] rx, input int d);
    logic [NR-1:0] cs_exp;
    int p, b, e_cs, e_sclk, e_mosi, e_rv;
    logic s_exp, m_exp;
    e_cs = 0; e_sclk = 0; e_mosi = 0; e_rv = 0;
    cs_exp = ~(NR'(1) << id);
    for (int n = 1; n <= 17 * d; n++) begin
      @(negedge clk);
      p = (n - 1) / d;
      b = (p / 2 > 7) ? 7 : p / 2;
      s_exp = (p % 2 == 1);
      m_exp = tx[7 - b];
      if (m_cs_n !== cs_exp) e_cs++;
      if (m_sclk !== s_exp) e_sclk++;
      if (m_mosi !== m_exp) e_mosi++;
      if (m_rv !== 1'b0) e_rv++;
    end
    total++; if (e_cs != 0)   begin bad++; $display("FAIL %s_cs_window bad_cycles=%0d required=0", tag, e_cs); end
    total++; if (e_sclk != 0) begin bad++; $display("FAIL %s_sclk_window bad_cycles=%0d required=0", tag, e_sclk); end
    total++; if (e_mosi != 0) begin bad++; $display("FAIL %s_mosi_window bad_cycles=%0d required=0 tx=%h", tag, e_mosi, tx); end
    total++; if (e_rv != 0)   begin bad++; $display("FAIL %s_early_rsp bad_cycles=%0d required=0", tag, e_rv); end
    @(negedge clk);
    total++; if (m_rv !== 1'b1)  begin bad++; $display("FAIL %s_rsp_valid got=%b required=1", tag, m_rv); end
    total++; if (m_cs_n !== '1)  begin bad++; $display("FAIL %s_cs_release got=%b required=11", tag, m_cs_n); end
    total++; if (m_rd !== rx)    begin bad++; $display("FAIL %s_rsp_data got=%h required=%h", tag, m_rd, rx); end
    total++; if (m_rid !== 1'(id)) begin bad++; $display("FAIL %s_rsp_id got=%0d required=%0d", tag, m_rid, id); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b0.req_valid = '1; b1.req_valid = '1;
    b0.req_data = 16'($urandom); b1.req_data = 16'($urandom);
    repeat (2) @(negedge clk);
    #1;
    total++; if (b0.cs_n !== 2'b11)     begin bad++; $display("FAIL reset_cs_n got=%b required=11", b0.cs_n); end
    total++; if (b0.sclk !== 1'b0)      begin bad++; $display("FAIL reset_sclk got=%b required=0", b0.sclk); end
    total++; if (b0.mosi !== 1'b0)      begin bad++; $display("FAIL reset_mosi got=%b required=0", b0.mosi); end
    total++; if (b0.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b required=00", b0.req_ready); end
    total++; if (b0.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b required=0", b0.rsp_valid); end
    total++; if (b0.rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data got=%h required=00", b0.rsp_data); end
    total++; if (b1.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready_d1 got=%b required=00", b1.req_ready); end
    total++; if (b1.cs_n !== 2'b11)     begin bad++; $display("FAIL reset_cs_n_d1 got=%b required=11", b1.cs_n); end
    b0.req_valid = '0; b1.req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int at;
    sel1 = 1'b0;
    set_data(0, 8'hA5); set_data(1, 8'($urandom)); set_req(2'b01);
    slave_byte = 8'h3C;
    wait_grant(at);
    total++; if (m_ready !== 2'b01) begin bad++; $display("FAIL single_grant got=%b required=01", m_ready); end
    ptr0_m = 1;
    @(posedge clk); #1; set_req('0);
    expect_xfer("single", 0, 8'hA5, 8'h3C, 2);
  endtask

  task automatic test_contention();
    logic [7:0] d [NR];
    logic [7:0] sb, tx;
    int at, prev, w;
    sel1 = 1'b0;
    prev = -1;
    for (int i = 0; i < NR; i++) begin d[i] = 8'($urandom); set_data(i, d[i]); end
    set_req(2'b11);
    for (int k = 0; k < 4; k++) begin
      w = rr_pick(2'b11, ptr0_m);
      wait_grant(at);
      total++; if (m_ready !== NR'(1 << w)) begin bad++; $display("FAIL contention_grant got=%b required=%b", m_ready, NR'(1 << w)); end
      if (prev >= 0) begin
        total++; if (at - prev != 36) begin bad++; $display("FAIL contention_gap got=%0d required=36", at - prev); end
      end
      prev = at;
      ptr0_m = (w + 1) % NR;
      sb = 8'($urandom); slave_byte = sb; tx = d[w];
      @(posedge clk); #1;
      d[w] = 8'($urandom); set_data(w, d[w]);
      expect_xfer("contention", w, tx, sb, 2);
    end
    set_req('0);
  endtask

  task automatic test_d1();
    logic [7:0] tx, sb;
    int at, w;
    sel1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w  = (k == 0) ? 0 : int'($urandom_range(0, NR - 1));
      tx = (k == 0) ? 8'hFF : 8'($urandom);
      sb = (k == 0) ? 8'h00 : 8'($urandom);
      set_data(w, tx); set_req(NR'(1 << w));
      slave_byte = sb;
      wait_grant(at);
      total++; if (m_ready !== NR'(1 << w)) begin bad++; $display("FAIL d1_grant got=%b required=%b", m_ready, NR'(1 << w)); end
      ptr1_m = (w + 1) % NR;
      @(posedge clk); #1; set_req('0);
      expect_xfer("d1", w, tx, sb, 1);
    end
    sel1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int at, e_idle;
    logic [7:0] tx;
    sel1 = 1'b0;
    tx = 8'($urandom); set_data(0, tx); set_req(2'b01);
    slave_byte = 8'($urandom);
    wait_grant(at);
    @(posedge clk); #1; set_req('0);
    repeat (15) @(negedge clk);
    total++; if (b0.sclk !== 1'b1) begin bad++; $display("FAIL mid_in_high got=%b required=1", b0.sclk); end
    rst_n = 1'b0;
    #1;
    total++; if (b0.cs_n !== 2'b11)     begin bad++; $display("FAIL mid_reset_cs_n got=%b required=11", b0.cs_n); end
    total++; if (b0.sclk !== 1'b0)      begin bad++; $display("FAIL mid_reset_sclk got=%b required=0", b0.sclk); end
    total++; if (b0.mosi !== 1'b0)      begin bad++; $display("FAIL mid_reset_mosi got=%b required=0", b0.mosi); end
    total++; if (b0.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_rsp_valid got=%b required=0", b0.rsp_valid); end
    total++; if (b0.rsp_data !== 8'h00) begin bad++; $display("FAIL mid_reset_rsp_data got=%h required=00", b0.rsp_data); end
    total++; if (b1.rsp_data !== 8'h00) begin bad++; $display("FAIL mid_reset_rsp_data_d1 got=%h required=00", b1.rsp_data); end
    ptr0_m = 0; ptr1_m = 0;
    @(negedge clk); rst_n = 1'b1;
    e_idle = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (b0.rsp_valid !== 1'b0 || b0.cs_n !== 2'b11) e_idle++;
    end
    total++; if (e_idle != 0) begin bad++; $display("FAIL mid_reset_no_rsp bad_cycles=%0d required=0", e_idle); end
    tx = 8'($urandom); set_data(0, tx); set_data(1, 8'($urandom)); set_req(2'b11);
    slave_byte = 8'($urandom);
    wait_grant(at);
    total++; if (m_ready !== NR'(1 << rr_pick(2'b11, ptr0_m))) begin bad++; $display("FAIL mid_reset_first_grant got=%b required=01", m_ready); end
    ptr0_m = 1;
    @(posedge clk); #1; set_req('0);
    expect_xfer("after_reset", 0, tx, slave_byte, 2);
  endtask

  task automatic test_withdrawn();
    int at, e_idle, e_busy;
    logic [7:0] tx;
    sel1 = 1'b0;
    tx = 8'($urandom); set_data(0, tx); set_req(2'b01);
    slave_byte = 8'($urandom);
    wait_grant(at);
    total++; if (m_ready !== 2'b01) begin bad++; $display("FAIL withdrawn_grant0 got=%b required=01", m_ready); end
    @(posedge clk); #1; set_req('0);
    repeat (5) @(negedge clk);
    set_req(2'b10); #1;
    total++; if (m_ready !== 2'b00) begin bad++; $display("FAIL withdrawn_busy_ready got=%b required=00", m_ready); end
    @(negedge clk); set_req('0);
    e_busy = 1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_rv === 1'b1) begin e_busy = 0; break; end
    end
    total++; if (e_busy != 0) begin bad++; $display("FAIL withdrawn_rsp_timeout got=none required=rsp_valid"); end
    total++; if (m_rd !== slave_byte) begin bad++; $display("FAIL withdrawn_rsp_data got=%h required=%h", m_rd, slave_byte); end
    e_idle = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_cs_n !== 2'b11 || m_ready !== 2'b00 || m_rv !== 1'b0) e_idle++;
    end
    total++; if (e_idle != 0) begin bad++; $display("FAIL withdrawn_idle bad_cycles=%0d required=0", e_idle); end
  endtask

  task automatic test_hold_stable();
    int at0, at1;
    logic [7:0] d, sb;
    sel1 = 1'b0;
    set_data(0, 8'($urandom)); set_req(2'b01);
    wait_grant(at0);
    @(posedge clk); #1; set_req('0);
    at1 = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      d = 8'($urandom); set_data(1, d); set_req(2'b10);
      #1;
      if (m_ready != '0) begin at1 = cyc; break; end
    end
    total++; if (m_ready !== 2'b10) begin bad++; $display("FAIL hold_grant got=%b required=10", m_ready); end
    total++; if (at1 - at0 != 36) begin bad++; $display("FAIL hold_gap got=%0d required=36", at1 - at0); end
    sb = 8'($urandom); slave_byte = sb;
    @(posedge clk); #1; set_req('0); set_data(1, ~d);
    expect_xfer("hold", 1, d, sb, 2);
  endtask

  initial begin
    b0.req_valid = '0; b0.req_data = '0;
    b1.req_valid = '0; b1.req_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_d1();
    test_reset_mid();
    test_withdrawn();
    test_hold_stable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
